// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: time-shares one external full_adder, LSB first, done WIDTH+1 cycles after start.
// start is honoured only in IDLE; requests while busy are dropped, not queued.
module serial_add_ctrl #(
   parameter int WIDTH = 4,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_y,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] s_sh;
   logic             carry;
   logic             last_bit;
   logic [WIDTH-1:0] s_nxt;

   assign last_bit = (count == CW'(WIDTH - 1));
   // Partial sum after this cycle's bit; on the last bit this is the full result.
   assign s_nxt    = {fa_y, s_sh};

   assign busy = (state == RUN) || (state == DONE);
   assign done = (state == DONE);

   always_comb begin
      state_nxt = state;
      fa_a      = 1'b0;
      fa_b      = 1'b0;
      fa_cin    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            fa_a   = a_sh[0];
            fa_b   = b_sh[0];
            fa_cin = carry;
            if (last_bit) state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  count <= '0;
               end
            end
            RUN: begin
               a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
               s_sh  <= s_nxt[WIDTH-1:1];
               carry <= fa_cout;
               count <= count + 1'b1;
               // Result registers only move on the final bit so they hold between operations.
               if (last_bit) begin
                  sum  <= s_nxt;
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: shared full_adder modelled here, results checked against plain a+b+cin.
module tb_serial_add_ctrl;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         fa_a, fa_b, fa_cin, fa_y, fa_cout;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int           n_chk  = 0;
   int           n_fail = 0;
   logic [W:0]   last_res;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_y(fa_y), .fa_cout(fa_cout),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   // Shared full_adder cell
   assign fa_y    = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_fa_zero(input string tag);
      check({tag, "_fa"}, {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
   endtask

   // One full operation; optionally hammers start with other operands while busy.
   task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input bit disturb, input string tag);
      logic [W:0]  exp;
      int          cyc;
      int          busy_n;
      int unsigned lo;
      exp   = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
      a     = av;
      b     = bv;
      cin   = cv;
      start = 1'b1;
      tick();
      start  = 1'b0;
      cyc    = 1;
      busy_n = 0;
      check({tag, "_hold"}, 32'({cout, sum}), 32'(last_res));
      while (done !== 1'b1 && cyc <= W + 4) begin
         if (cyc <= W) begin
            lo = (32'(av) % (32'd1 << (cyc-1))) + (32'(bv) % (32'd1 << (cyc-1))) + 32'(cv);
            check({tag, "_fa_a"},   32'(fa_a),   32'(av[cyc-1]));
            check({tag, "_fa_b"},   32'(fa_b),   32'(bv[cyc-1]));
            check({tag, "_fa_cin"}, 32'(fa_cin), (lo >> (cyc-1)) & 32'd1);
         end
         busy_n += int'(busy);
         if (disturb) begin
            start = 1'b1;
            a     = W'($urandom_range(0, (1 << W) - 1));
            b     = W'($urandom_range(0, (1 << W) - 1));
            cin   = 1'($urandom_range(0, 1));
         end
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
      if (done === 1'b1) begin
         busy_n += int'(busy);
         check({tag, "_busy_n"}, 32'(busy_n), 32'(W + 1));
         check({tag, "_result"}, 32'({cout, sum}), 32'(exp));
         check_fa_zero({tag, "_done"});
      end
      tick();
      start = 1'b0;
      check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
      check_fa_zero({tag, "_idle"});
      last_res = exp;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_done;
      int n_done;
      int exp_n;
      int guard;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      last_res = '0;
      #2;
      check("reset_out", {26'd0, busy, done, cout, fa_a, fa_b, fa_cin}, 32'd0);
      check("reset_sum", 32'(sum), 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      check("post_reset_idle", {30'd0, busy, done}, 32'd0);

      do_add(4'd3,  4'd5,  1'b0, 1'b0, "add_3_5");
      do_add(4'd15, 4'd1,  1'b0, 1'b0, "add_15_1");
      do_add(4'd15, 4'd15, 1'b1, 1'b0, "add_15_15_1");
      do_add(4'd0,  4'd0,  1'b1, 1'b0, "ripple_0_0_1");
      do_add(4'd10, 4'd4,  1'b0, 1'b1, "ignore_start");
      for (int i = 0; i < 8; i++)
         do_add(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), i[0], "random");

      // Reset in the second RUN cycle
      a = 4'd11; b = 4'd12; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_out", {26'd0, busy, done, cout, fa_a, fa_b, fa_cin}, 32'd0);
      check("arst_sum", 32'(sum), 32'd0);
      n_done = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_done += int'(done);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_done += int'(done);
      end
      check("arst_no_done", 32'(n_done), 32'd0);
      last_res = '0;
      do_add(4'd6, 4'd7, 1'b0, 1'b0, "after_rst_6_7");

      // start held high: back-to-back operations every W+2 cycles
      a = 4'd9; b = 4'd9; cin = 1'b0; start = 1'b1;
      exp_done = W + 1;
      n_done   = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (!busy || done) check_fa_zero("held_idle_done");
         if (done === 1'b1) begin
            n_done++;
            check("held_done_cycle", 32'(k), 32'(exp_done));
            check("held_result", 32'({cout, sum}), 32'd18);
            exp_done += W + 2;
         end
      end
      exp_n = 0;
      for (int e = W + 1; e <= 20; e += W + 2) exp_n++;
      check("held_done_count", 32'(n_done), 32'(exp_n));
      start = 1'b0;
      guard = 0;
      while (busy === 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      check("held_drain", 32'(busy), 32'd0);
      check("held_final", 32'({cout, sum}), 32'd18);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
